// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pll_seq_pkg : shared state encoding and helpers for the PLL lock sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    DEBOUNCE  = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pll_lock_sequencer_if : PLL control / staged reset signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface pll_lock_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 16
);
  logic                  pll_locked_i;
  logic                  force_relock_i;
  logic                  pll_rst_o;
  logic [NUM_STAGES-1:0] stage_rst_n_o;
  logic                  ready_o;
  logic [STATE_W-1:0]    state_o;
  logic [CNT_W-1:0]      lock_loss_cnt_o;
  logic [CNT_W-1:0]      timeout_cnt_o;

  modport master (
    output pll_locked_i, force_relock_i,
    input  pll_rst_o, stage_rst_n_o, ready_o, state_o, lock_loss_cnt_o, timeout_cnt_o
  );

  modport slave (
    input  pll_locked_i, force_relock_i,
    output pll_rst_o, stage_rst_n_o, ready_o, state_o, lock_loss_cnt_o, timeout_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_2ff : generic two-flop synchroniser for asynchronous level inputs
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pll_lock_sequencer : drives PLL reset, qualifies lock, releases staged resets
// Rev 1.0
// ----------------------------------------------------------------------------
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 10000,
  parameter int STABLE_CYCLES = 1000,
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_GAP     = 16,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pll_lock_sequencer_if.slave bus
);
  localparam int TMAX    = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                max2(STABLE_CYCLES, STAGE_GAP * NUM_STAGES));
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_DONE    = IDX_W'(NUM_STAGES);

  logic                  lock_s;
  pll_state_e            state_q;
  logic [TIMER_W-1:0]    timer_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  pll_rst_q;
  logic                  ready_q;
  logic [NUM_STAGES-1:0] stage_q;
  logic [CNT_W-1:0]      lock_loss_cnt_q, lock_loss_cnt_d;
  logic [CNT_W-1:0]      timeout_cnt_q, timeout_cnt_d;
  logic                  loss_in_run, wait_timeout, to_reset;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.pll_locked_i),
    .q_o   (lock_s)
  );

  assign lock_loss_cnt_d = (&lock_loss_cnt_q) ? lock_loss_cnt_q : lock_loss_cnt_q + 1'b1;
  assign timeout_cnt_d   = (&timeout_cnt_q) ? timeout_cnt_q : timeout_cnt_q + 1'b1;

  // A forced relock takes the PLL down without being logged as a timeout.
  assign loss_in_run  = (state_q == RUN) && !lock_s;
  assign wait_timeout = (state_q == WAIT_LOCK) && !lock_s && !bus.force_relock_i &&
                        (timer_q == LOCK_LAST);
  assign to_reset     = (state_q != RESET_PLL) &&
                        (bus.force_relock_i || wait_timeout ||
                         (!lock_s && ((state_q == RELEASE) || (state_q == RUN))));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= RESET_PLL;
      timer_q         <= '0;
      idx_q           <= '0;
      pll_rst_q       <= 1'b1;
      ready_q         <= 1'b0;
      stage_q         <= '0;
      lock_loss_cnt_q <= '0;
      timeout_cnt_q   <= '0;
    end else if (to_reset) begin
      state_q   <= RESET_PLL;
      timer_q   <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      stage_q   <= '0;
      if (loss_in_run)  lock_loss_cnt_q <= lock_loss_cnt_d;
      if (wait_timeout) timeout_cnt_q   <= timeout_cnt_d;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (timer_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            pll_rst_q <= 1'b0;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= DEBOUNCE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            timer_q <= '0;
          end else if (timer_q == STABLE_LAST) begin
            state_q <= RELEASE;
            timer_q <= '0;
            idx_q   <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RELEASE: begin
          // Stages fill from bit 0 upward, one per STAGE_GAP cycles.
          if (idx_q == IDX_DONE) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else if (timer_q == GAP_LAST) begin
            stage_q <= (stage_q << 1) | NUM_STAGES'(1);
            idx_q   <= idx_q + 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q   <= RESET_PLL;
          timer_q   <= '0;
          pll_rst_q <= 1'b1;
          ready_q   <= 1'b0;
          stage_q   <= '0;
        end
      endcase
    end
  end

  assign bus.pll_rst_o       = pll_rst_q;
  assign bus.stage_rst_n_o   = stage_q;
  assign bus.ready_o         = ready_q;
  assign bus.state_o         = state_q;
  assign bus.lock_loss_cnt_o = lock_loss_cnt_q;
  assign bus.timeout_cnt_o   = timeout_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pll_lock_sequencer : vector table, corner sequences and random run vs model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int RC = 4, LT = 50, SC = 8, NS = 3, SG = 4, CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pll_lock_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  pll_lock_sequencer #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .NUM_STAGES(NS), .STAGE_GAP(SG), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode plus cycles spent in it, and the two-stage lock delay line.
  int m_mode, m_age, m_llc, m_toc;
  bit m_s1, m_s2;

  function automatic int m_stage();
    int v = 0;
    for (int k = 0; k < NS; k++)
      if (m_mode == 4 || (m_mode == 3 && m_age >= SG * (k + 1))) v |= (1 << k);
    return v;
  endfunction

  task automatic goto_mode(input int md);
    m_mode = md;
    m_age  = 0;
  endtask

  task automatic model_edge();
    bit ls, fr;
    ls = m_s2;
    fr = bus.force_relock_i;
    if (!rst_n) begin
      goto_mode(0);
      m_llc = 0; m_toc = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = bus.pll_locked_i;
      case (m_mode)
        0: if (m_age == RC - 1) goto_mode(1); else m_age++;
        1: if (fr) goto_mode(0);
           else if (ls) goto_mode(2);
           else if (m_age == LT - 1) begin
             if (m_toc < CMAX) m_toc++;
             goto_mode(0);
           end else m_age++;
        2: if (fr) goto_mode(0);
           else if (!ls) goto_mode(1);
           else if (m_age == SC - 1) goto_mode(3);
           else m_age++;
        3: if (fr || !ls) goto_mode(0);
           else if (m_age == SG * NS) goto_mode(4);
           else m_age++;
        default: if (!ls) begin
             if (m_llc < CMAX) m_llc++;
             goto_mode(0);
           end else if (fr) goto_mode(0);
      endcase
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("state",   int'(bus.state_o),         m_mode);
    check("pll_rst", int'(bus.pll_rst_o),       int'(m_mode == 0));
    check("stage",   int'(bus.stage_rst_n_o),   m_stage());
    check("ready",   int'(bus.ready_o),         int'(m_mode == 4));
    check("llc",     int'(bus.lock_loss_cnt_o), m_llc);
    check("toc",     int'(bus.timeout_cnt_o),   m_toc);
  endtask

  task automatic step(input bit r, input bit l, input bit f);
    rst_n              = r;
    bus.pll_locked_i   = l;
    bus.force_relock_i = f;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Bounded advance with lock held until the model reaches mode/age.
  task automatic advance_to(input int md, input int age, input string name);
    for (int k = 0; k < 400 && !(m_mode == md && m_age == age); k++) step(1, 1, 0);
    check(name, int'(bus.state_o), md);
  endtask

  typedef struct {
    int            n;
    bit            r, l, f;
    int            st;
    bit            prst;
    logic [NS-1:0] stg;
    bit            rdy;
    int            llc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    vecs = '{
      '{2, 0, 0, 0, 0, 1, 3'b000, 0, 0},
      '{3, 1, 0, 0, 0, 1, 3'b000, 0, 0},
      '{1, 1, 0, 0, 1, 0, 3'b000, 0, 0},
      '{2, 1, 1, 0, 1, 0, 3'b000, 0, 0},
      '{1, 1, 1, 0, 2, 0, 3'b000, 0, 0},
      '{7, 1, 1, 0, 2, 0, 3'b000, 0, 0},
      '{1, 1, 1, 0, 3, 0, 3'b000, 0, 0},
      '{3, 1, 1, 0, 3, 0, 3'b000, 0, 0},
      '{1, 1, 1, 0, 3, 0, 3'b001, 0, 0},
      '{3, 1, 1, 0, 3, 0, 3'b001, 0, 0},
      '{1, 1, 1, 0, 3, 0, 3'b011, 0, 0},
      '{3, 1, 1, 0, 3, 0, 3'b011, 0, 0},
      '{1, 1, 1, 0, 3, 0, 3'b111, 0, 0},
      '{1, 1, 1, 0, 4, 0, 3'b111, 1, 0},
      '{5, 1, 1, 0, 4, 0, 3'b111, 1, 0},
      '{2, 1, 0, 0, 4, 0, 3'b111, 1, 0},
      '{1, 1, 0, 0, 0, 1, 3'b000, 0, 1}
    };

    // Bring-up, staged release and lock loss in RUN
    for (int i = 0; i < NV; i++) begin
      repeat (vecs[i].n) step(vecs[i].r, vecs[i].l, vecs[i].f);
      check($sformatf("v%0d_state", i), int'(bus.state_o),       vecs[i].st);
      check($sformatf("v%0d_prst", i),  int'(bus.pll_rst_o),     int'(vecs[i].prst));
      check($sformatf("v%0d_stage", i), int'(bus.stage_rst_n_o), int'(vecs[i].stg));
      check($sformatf("v%0d_ready", i), int'(bus.ready_o),       int'(vecs[i].rdy));
      check($sformatf("v%0d_llc", i),   int'(bus.lock_loss_cnt_o), vecs[i].llc);
    end
    advance_to(4, 0, "relock_run");

    // Repeated timeouts with lock held low, counter saturating
    step(0, 0, 0);
    for (int i = 1; i <= 270; i++) begin
      step(1, 0, 0);
      if (i == 54) begin
        check("to1_cnt",  int'(bus.timeout_cnt_o), 1);
        check("to1_prst", int'(bus.pll_rst_o), 1);
      end
    end
    check("to_sat",   int'(bus.timeout_cnt_o), 3);
    check("to_state", int'(bus.state_o), 0);

    // One-cycle lock glitch late in debounce
    step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    repeat (3) step(1, 1, 0);
    check("gl_deb", int'(bus.state_o), 2);
    repeat (5) step(1, 1, 0);
    step(1, 0, 0);
    repeat (2) step(1, 1, 0);
    check("gl_wait",  int'(bus.state_o), 1);
    check("gl_stage", int'(bus.stage_rst_n_o), 0);
    step(1, 1, 0);
    check("gl_redeb", int'(bus.state_o), 2);
    advance_to(4, 0, "gl_run");

    // Forced relock from RUN, then a force pulse inside RESET_PLL
    step(1, 1, 1);
    check("fr_state", int'(bus.state_o), 0);
    check("fr_llc",   int'(bus.lock_loss_cnt_o), 0);
    check("fr_toc",   int'(bus.timeout_cnt_o), 0);
    step(1, 1, 1);
    repeat (2) step(1, 1, 0);
    check("fr_hold", int'(bus.state_o), 0);
    step(1, 1, 0);
    check("fr_exit", int'(bus.state_o), 1);

    // Reset asserted in the middle of RELEASE
    advance_to(3, 6, "rr_rel");
    check("rr_stage_mid", int'(bus.stage_rst_n_o), 1);
    step(0, 1, 0);
    check("rr_state", int'(bus.state_o), 0);
    check("rr_prst",  int'(bus.pll_rst_o), 1);
    check("rr_stage", int'(bus.stage_rst_n_o), 0);
    check("rr_ready", int'(bus.ready_o), 0);

    // Random lock behaviour, occasional forces and resets
    begin
      bit lk = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 39) == 0) lk = ~lk;
        step(($urandom_range(0, 599) != 0), lk, ($urandom_range(0, 199) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
